acs_scheduler: RTL



---
 rtl/viterbi_pkg.sv | 29 ++
 rtl/acs_scheduler_if.sv | 42 ++++
 rtl/acs_issue_pipe.sv | 24 ++
 rtl/acs_scheduler.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder definitions: trellis size defaults, scheduler FSM
// encoding and the predecessor-index helper used by the ACS sequencing logic.
package viterbi_pkg;

  localparam int K_DEF      = 5;
  localparam int M_DEF      = K_DEF - 1;
  localparam int S_DEF      = 1 << M_DEF;
  localparam int STEP_W_DEF = 16;
  localparam int IDX_MAX_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_SYM,
    ST_RUN,
    ST_DRAIN
  } sched_state_t;

  // Trellis shifts the input bit in at the LSB, so the predecessors of j
  // differ only in the bit that was shifted out at the top.
  function automatic logic [IDX_MAX_W-1:0] pred(input logic [IDX_MAX_W-1:0] j,
                                                input logic                 b,
                                                input int                   m);
    logic [IDX_MAX_W-1:0] hi;
    hi = IDX_MAX_W'(b) << (m - 1);
    return (j >> 1) | hi;
  endfunction

endpackage

// File: rtl/acs_scheduler_if.sv
// Bundle of the scheduler's symbol handshake, pm_bank controls and ACS
// sequencing signals; master is the scheduler, slave the surrounding datapath.
interface acs_scheduler_if
  import viterbi_pkg::*;
#(
  parameter int M      = M_DEF,
  parameter int STEP_W = STEP_W_DEF
);

  logic              frame_start;
  logic              sym_valid;
  logic              sym_last;
  logic              sym_ready;
  logic              acs_pm_hi;
  logic              pm_init_frame;
  logic              pm_swap_banks;
  logic [M-1:0]      pm_rd_idx0;
  logic [M-1:0]      pm_rd_idx1;
  logic              pm_wr_en;
  logic [M-1:0]      pm_wr_idx;
  logic              acs_issue;
  logic [M-1:0]      acs_state;
  logic              norm_sub;
  logic [STEP_W-1:0] dec_step;
  logic              busy;
  logic              frame_done;

  modport master (
    input  frame_start, sym_valid, sym_last, acs_pm_hi,
    output sym_ready, pm_init_frame, pm_swap_banks, pm_rd_idx0, pm_rd_idx1,
           pm_wr_en, pm_wr_idx, acs_issue, acs_state, norm_sub, dec_step,
           busy, frame_done
  );

  modport slave (
    output frame_start, sym_valid, sym_last, acs_pm_hi,
    input  sym_ready, pm_init_frame, pm_swap_banks, pm_rd_idx0, pm_rd_idx1,
           pm_wr_en, pm_wr_idx, acs_issue, acs_state, norm_sub, dec_step,
           busy, frame_done
  );

endinterface

// File: rtl/acs_issue_pipe.sv
// One-stage delay from ACS issue to pm_bank/survivor write, matching the
// registered ACS result that lands one cycle after its operands are read.
module acs_issue_pipe #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue_valid,
  input  logic [M-1:0] issue_idx,
  output logic         wr_en,
  output logic [M-1:0] wr_idx
);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en  <= 1'b0;
      wr_idx <= '0;
    end else begin
      wr_en  <= issue_valid;
      wr_idx <= issue_idx;
    end
  end

endmodule

// File: rtl/acs_scheduler.sv
// Sequencing controller for the path-metric bank and ACS unit: initialises the
// bank per frame, then walks all trellis states once per accepted symbol.
module acs_scheduler
  import viterbi_pkg::*;
#(
  parameter int K      = K_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  acs_scheduler_if.master  bus
);

  localparam int M = K - 1;
  localparam int S = 1 << M;

  sched_state_t      state;
  sched_state_t      state_nxt;
  logic [M-1:0]      j;
  logic              sym_last_q;
  logic [STEP_W-1:0] step_cnt;
  logic              norm_flag;
  logic              norm_sub_q;
  logic              wr_en;
  logic [M-1:0]      wr_idx;
  logic              hi_write;

  logic              sym_ready_c;
  logic              init_c;
  logic              swap_c;
  logic              issue_c;
  logic [M-1:0]      state_idx_c;
  logic [M-1:0]      rd0_c;
  logic [M-1:0]      rd1_c;
  logic              done_c;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (bus.frame_start) state_nxt = ST_INIT;
      ST_INIT:     state_nxt = ST_WAIT_SYM;
      ST_WAIT_SYM: if (bus.sym_valid) state_nxt = ST_RUN;
      ST_RUN:      if (j == M'(S - 1)) state_nxt = ST_DRAIN;
      ST_DRAIN:    state_nxt = sym_last_q ? ST_IDLE : ST_WAIT_SYM;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sym_ready_c = 1'b0;
    init_c      = 1'b0;
    swap_c      = 1'b0;
    issue_c     = 1'b0;
    state_idx_c = '0;
    rd0_c       = '0;
    rd1_c       = '0;
    done_c      = 1'b0;
    case (state)
      // Init and swap together: the freshly cleared bank becomes "previous".
      ST_INIT: begin
        init_c = 1'b1;
        swap_c = 1'b1;
      end
      ST_WAIT_SYM: sym_ready_c = 1'b1;
      ST_RUN: begin
        issue_c     = 1'b1;
        state_idx_c = j;
        rd0_c       = M'(pred(IDX_MAX_W'(j), 1'b0, M));
        rd1_c       = M'(pred(IDX_MAX_W'(j), 1'b1, M));
      end
      ST_DRAIN: begin
        swap_c = 1'b1;
        done_c = sym_last_q;
      end
      default: ;
    endcase
  end

  assign hi_write = wr_en & bus.acs_pm_hi;

  // The last write of a step lands in DRAIN, so its MSB still feeds norm_sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      j          <= '0;
      sym_last_q <= 1'b0;
      step_cnt   <= '0;
      norm_flag  <= 1'b0;
      norm_sub_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          step_cnt   <= '0;
          norm_sub_q <= 1'b0;
        end
        ST_WAIT_SYM: begin
          if (bus.sym_valid) begin
            sym_last_q <= bus.sym_last;
            j          <= '0;
          end
        end
        ST_RUN: j <= j + 1'b1;
        ST_DRAIN: begin
          step_cnt   <= step_cnt + 1'b1;
          norm_sub_q <= norm_flag | hi_write;
        end
        default: ;
      endcase

      if (state == ST_IDLE || state == ST_DRAIN) norm_flag <= 1'b0;
      else if (hi_write)                         norm_flag <= 1'b1;
    end
  end

  acs_issue_pipe #(.M(M)) u_issue_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_c),
    .issue_idx   (state_idx_c),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx)
  );

  assign bus.sym_ready     = sym_ready_c;
  assign bus.pm_init_frame = init_c;
  assign bus.pm_swap_banks = swap_c;
  assign bus.pm_rd_idx0    = rd0_c;
  assign bus.pm_rd_idx1    = rd1_c;
  assign bus.pm_wr_en      = wr_en;
  assign bus.pm_wr_idx     = wr_idx;
  assign bus.acs_issue     = issue_c;
  assign bus.acs_state     = state_idx_c;
  assign bus.norm_sub      = norm_sub_q;
  assign bus.dec_step      = step_cnt;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.frame_done    = done_c;

endmodule
